// File: rtl/aes_decrypt_ctrl_pkg.sv
// Shared types and constants for the AES-128 decryption sequencer.
//   fsm_e : controller states
//   sel_e : state-register input mux select driven to the datapath
package aes_decrypt_ctrl_pkg;
  localparam int NR      = 10;    // AES-128 round count; round keys 0..NR
  localparam int NK_BITS = 1408;  // full expanded key schedule width
  localparam int RK_W    = 128;   // one round key

  typedef enum logic [3:0] {
    IDLE, LOAD, WAIT_KEY, ARK0, ISR, ISB, ARK, IMC, DONE
  } fsm_e;

  typedef enum logic [2:0] {
    SEL_HOLD = 3'd0,
    SEL_CT   = 3'd1,
    SEL_ISR  = 3'd2,
    SEL_ISB  = 3'd3,
    SEL_ARK  = 3'd4,
    SEL_IMC  = 3'd5
  } sel_e;
endpackage

// File: rtl/aes_decrypt_ctrl_if.sv
// Control bundle between the decryption sequencer and the AES datapath/wrapper.
//   start     : level request from the bus wrapper
//   state_ld  : state-register load enable
//   state_sel : state-register input mux select
//   imc_col   : column routed to the single InvMixColumns unit
//   rk_idx    : round-key index into the key schedule
//   busy/done : run status back to the wrapper
// master = wrapper/datapath side, slave = sequencer.
interface aes_decrypt_ctrl_if;
  import aes_decrypt_ctrl_pkg::*;

  logic       start;
  logic       state_ld;
  sel_e       state_sel;
  logic [1:0] imc_col;
  logic [3:0] rk_idx;
  logic       busy;
  logic       done;

  modport master (output start,
                  input  state_ld, state_sel, imc_col, rk_idx, busy, done);
  modport slave  (input  start,
                  output state_ld, state_sel, imc_col, rk_idx, busy, done);
endinterface

// File: rtl/aes_decrypt_ctrl.sv
// AES-128 decryption sequencer. After start it latches the ciphertext, waits
// for the key expansion to settle, then steps the datapath through the initial
// AddRoundKey, NR-1 full inverse rounds (ISR, ISB, ARK, 4x IMC column) and the
// final round (no IMC). All outputs are registered and decoded from the state
// being entered, so they line up with the registered FSM state.
// Ports: clk, reset (async, active-high), bus (aes_decrypt_ctrl_if.slave).
module aes_decrypt_ctrl
  import aes_decrypt_ctrl_pkg::*;
#(
  parameter int KEYEXP_CYCLES = 10
) (
  input  logic               clk,
  input  logic               reset,
  aes_decrypt_ctrl_if.slave  bus
);

  localparam int             WW        = (KEYEXP_CYCLES > 1) ? $clog2(KEYEXP_CYCLES) : 1;
  localparam logic [WW-1:0]  WAIT_LAST = WW'(KEYEXP_CYCLES - 1);
  localparam logic [3:0]     NR_L      = 4'(NR);

  fsm_e          st_q, st_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [3:0]    r_q, r_d;
  logic [1:0]    imc_q, imc_d;
  logic [3:0]    rk_q, rk_d;
  logic          ld_q, ld_d;
  sel_e          sel_q, sel_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    st_d   = st_q;
    wait_d = wait_q;
    r_d    = r_q;
    imc_d  = imc_q;
    rk_d   = rk_q;   // rk_idx/imc_col hold outside ARK/IMC

    unique case (st_q)
      IDLE:     if (bus.start) st_d = LOAD;
      LOAD: begin
        st_d   = WAIT_KEY;
        wait_d = WAIT_LAST;
      end
      WAIT_KEY: begin
        if (wait_q == '0) begin
          st_d = ARK0;
          rk_d = NR_L;
        end else begin
          wait_d = wait_q - 1'b1;
        end
      end
      ARK0: begin
        st_d = ISR;
        r_d  = 4'd1;
      end
      ISR:      st_d = ISB;
      ISB: begin
        st_d = ARK;
        rk_d = NR_L - r_q;
      end
      ARK: begin
        if (r_q < NR_L) begin
          st_d  = IMC;
          imc_d = 2'd0;
        end else begin
          st_d = DONE;
        end
      end
      IMC: begin
        if (imc_q == 2'd3) begin
          st_d = ISR;
          r_d  = r_q + 4'd1;
        end else begin
          imc_d = imc_q + 2'd1;
        end
      end
      // Requires start low before leaving, so a held request never re-triggers.
      DONE:     if (!bus.start) st_d = IDLE;
      default:  st_d = IDLE;
    endcase
  end

  // Moore outputs for the state being entered, registered alongside it.
  always_comb begin
    ld_d   = 1'b0;
    sel_d  = SEL_HOLD;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (st_d)
      LOAD:     begin ld_d = 1'b1; sel_d = SEL_CT;  busy_d = 1'b1; end
      WAIT_KEY: busy_d = 1'b1;
      ARK0,
      ARK:      begin ld_d = 1'b1; sel_d = SEL_ARK; busy_d = 1'b1; end
      ISR:      begin ld_d = 1'b1; sel_d = SEL_ISR; busy_d = 1'b1; end
      ISB:      begin ld_d = 1'b1; sel_d = SEL_ISB; busy_d = 1'b1; end
      IMC:      begin ld_d = 1'b1; sel_d = SEL_IMC; busy_d = 1'b1; end
      DONE:     done_d = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q   <= IDLE;
      wait_q <= '0;
      r_q    <= 4'd0;
      imc_q  <= 2'd0;
      rk_q   <= 4'd0;
      ld_q   <= 1'b0;
      sel_q  <= SEL_HOLD;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      wait_q <= wait_d;
      r_q    <= r_d;
      imc_q  <= imc_d;
      rk_q   <= rk_d;
      ld_q   <= ld_d;
      sel_q  <= sel_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign bus.state_ld  = ld_q;
  assign bus.state_sel = sel_q;
  assign bus.imc_col   = imc_q;
  assign bus.rk_idx    = rk_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_aes_decrypt_ctrl.sv
// Bench for the AES-128 decryption sequencer: compares every cycle of a run
// against an expected trace built from the round schedule, plus latency,
// load/busy counts, key order, start handshake and mid-run reset.
module tb_aes_decrypt_ctrl;
  localparam int KEYEXP = 10;
  localparam int NRND   = 10;
  localparam int S_HOLD = 0, S_CT = 1, S_ISR = 2, S_ISB = 3, S_ARK = 4, S_IMC = 5;

  typedef struct {
    int ld; int sel; int busy; int done; int rk; int imc;
  } step_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  step_t tr[$];

  aes_decrypt_ctrl_if bif ();

  aes_decrypt_ctrl #(.KEYEXP_CYCLES(KEYEXP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  function automatic void add(input int ld, input int sel, input int busy,
                              input int done, input int rk, input int imc);
    step_t s;
    s.ld = ld; s.sel = sel; s.busy = busy; s.done = done; s.rk = rk; s.imc = imc;
    tr.push_back(s);
  endfunction

  // Expected cycle-by-cycle behaviour after start is sampled (index 0 = LOAD).
  function automatic void build_trace();
    tr.delete();
    add(1, S_CT, 1, 0, -1, -1);
    for (int i = 0; i < KEYEXP; i++) add(0, S_HOLD, 1, 0, -1, -1);
    add(1, S_ARK, 1, 0, NRND, -1);
    for (int r = 1; r <= NRND; r++) begin
      add(1, S_ISR, 1, 0, -1, -1);
      add(1, S_ISB, 1, 0, -1, -1);
      add(1, S_ARK, 1, 0, NRND - r, -1);
      if (r < NRND)
        for (int c = 0; c < 4; c++) add(1, S_IMC, 1, 0, -1, c);
    end
    add(0, S_HOLD, 0, 1, -1, -1);
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(bif.busy), 0);
    chk({tag, "_done"}, 32'(bif.done), 0);
    chk({tag, "_ld"},   32'(bif.state_ld), 0);
  endtask

  // One run from IDLE. glitch: randomize start while busy. abort_at: trace
  // index at which reset is asserted mid-cycle (-1 = run to completion).
  task automatic run(input bit glitch, input int abort_at);
    int cyc, lat, nld, nbusy;
    int rkq[$];
    int imcq[$];
    lat = -1; nld = 0; nbusy = 0;
    @(negedge clk) bif.start = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 200) begin
      #1;
      if (cyc < tr.size()) begin
        chk($sformatf("c%0d_ld", cyc),   32'(bif.state_ld),  32'(tr[cyc].ld));
        chk($sformatf("c%0d_sel", cyc),  32'(bif.state_sel), 32'(tr[cyc].sel));
        chk($sformatf("c%0d_busy", cyc), 32'(bif.busy),      32'(tr[cyc].busy));
        chk($sformatf("c%0d_done", cyc), 32'(bif.done),      32'(tr[cyc].done));
        if (tr[cyc].rk >= 0)  chk($sformatf("c%0d_rk", cyc),  32'(bif.rk_idx),  32'(tr[cyc].rk));
        if (tr[cyc].imc >= 0) chk($sformatf("c%0d_imc", cyc), 32'(bif.imc_col), 32'(tr[cyc].imc));
      end
      if (cyc == abort_at) begin
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(bif.busy),      0);
        chk("rst_mid_done", 32'(bif.done),      0);
        chk("rst_mid_ld",   32'(bif.state_ld),  0);
        chk("rst_mid_sel",  32'(bif.state_sel), 0);
        chk("rst_mid_rk",   32'(bif.rk_idx),    0);
        chk("rst_mid_imc",  32'(bif.imc_col),   0);
        return;
      end
      if (bif.state_ld === 1'b1) nld++;
      if (bif.busy === 1'b1) nbusy++;
      if (bif.state_sel == 3'(S_ARK)) rkq.push_back(int'(bif.rk_idx));
      if (bif.state_sel == 3'(S_IMC)) imcq.push_back(int'(bif.imc_col));
      if (bif.done === 1'b1) begin
        lat = cyc;
        break;
      end
      @(negedge clk) bif.start = glitch ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      cyc++;
    end
    // LOAD + WAIT_KEY + ARK0 + 9 full rounds + final round
    chk("latency",   32'(lat),   32'(1 + KEYEXP + 1 + (NRND - 1) * 7 + 3));
    chk("ld_count",  32'(nld),   32'(1 + 1 + (NRND - 1) * 7 + 3));
    chk("busy_cnt",  32'(nbusy), 32'(1 + KEYEXP + 1 + (NRND - 1) * 7 + 3));
    chk("rk_len",    32'(rkq.size()), 32'(NRND + 1));
    for (int i = 0; i < rkq.size() && i <= NRND; i++)
      chk($sformatf("rk_order%0d", i), 32'(rkq[i]), 32'(NRND - i));
    chk("imc_len",   32'(imcq.size()), 32'(4 * (NRND - 1)));
    for (int i = 0; i < imcq.size() && i < 4 * (NRND - 1); i++)
      chk($sformatf("imc_order%0d", i), 32'(imcq[i]), 32'(i % 4));
  endtask

  task automatic back_to_idle(input string tag);
    @(negedge clk) bif.start = 1'b0;
    @(posedge clk);
    #1 chk_idle(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    build_trace();
    bif.start = 1'b0;
    reset     = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("rst_ld",   32'(bif.state_ld),  0);
    chk("rst_sel",  32'(bif.state_sel), 0);
    chk("rst_imc",  32'(bif.imc_col),   0);
    chk("rst_rk",   32'(bif.rk_idx),    0);
    chk("rst_busy", 32'(bif.busy),      0);
    chk("rst_done", 32'(bif.done),      0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    repeat ($urandom_range(1, 5)) begin
      @(posedge clk);
      #1 chk_idle("pre_idle");
    end

    // Nominal run
    run(1'b0, -1);
    back_to_idle("nom_idle");

    // start toggled randomly while busy
    for (int k = 0; k < 2; k++) begin
      repeat ($urandom_range(1, 4)) @(posedge clk);
      run(1'b1, -1);
      back_to_idle("glitch_idle");
    end

    // start held through DONE: stays in DONE, then drop and restart
    run(1'b0, -1);
    @(negedge clk) bif.start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("hold_done", 32'(bif.done),     1);
      chk("hold_busy", 32'(bif.busy),     0);
      chk("hold_ld",   32'(bif.state_ld), 0);
    end
    back_to_idle("hold_drop");
    run(1'b0, -1);
    back_to_idle("rerun_idle");

    // Reset in the middle of round 4's IMC (trace index 37 = column 1)
    run(1'b0, 12 + 3 * 7 + 4);
    @(negedge clk) reset = 1'b0;
    bif.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1 chk_idle("post_rst");
    end
    run(1'b0, -1);
    back_to_idle("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
